// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchronizer, consecutive-cycle glitch filter and edge pulses.
// Build macro SYNC_FILTER_GLITCH_DETECT_EN adds a sticky per-channel rejected-glitch flag.
module sync_filter #(
    parameter int unsigned       NUM_CH        = 1,
    parameter int unsigned       STAGES        = 2,
    parameter int unsigned       FILTER_CYCLES = 1,
    parameter logic [NUM_CH-1:0] RESET_VALUE   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] serial_i,
    output logic [NUM_CH-1:0] serial_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
`ifdef SYNC_FILTER_GLITCH_DETECT_EN
    ,
    input  logic [NUM_CH-1:0] glitch_clr_i,
    output logic [NUM_CH-1:0] glitch_o
`endif
);

    localparam int unsigned      CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("sync_filter: STAGES must lie in 2..8");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter: FILTER_CYCLES must be at least 1");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("sync_filter: NUM_CH must be at least 1");
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [STAGES-1:0] sync_reg;
        logic [CNT_W-1:0]  cnt_reg;
        logic              filt_reg;
        logic              prev_reg;
        logic              sync_last;

        assign sync_last = sync_reg[STAGES-1];

        // The counter tracks consecutive disagreement; any agreement restarts it.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_reg <= {STAGES{RESET_VALUE[gi]}};
                cnt_reg  <= '0;
                filt_reg <= RESET_VALUE[gi];
                prev_reg <= RESET_VALUE[gi];
            end else begin
                sync_reg <= {sync_reg[STAGES-2:0], serial_i[gi]};
                prev_reg <= filt_reg;
                if (sync_last == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    filt_reg <= sync_last;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end

        assign serial_o[gi] = filt_reg;
        assign rise_o[gi]   = filt_reg & ~prev_reg;
        assign fall_o[gi]   = ~filt_reg & prev_reg;

`ifdef SYNC_FILTER_GLITCH_DETECT_EN
        logic glitch_reg;
        logic glitch_set;

        // A disagreement that collapses before acceptance is a rejected glitch.
        assign glitch_set = (sync_last == filt_reg) && (cnt_reg != '0);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                glitch_reg <= 1'b0;
            end else begin
                glitch_reg <= glitch_set | (glitch_reg & ~glitch_clr_i[gi]);
            end
        end

        assign glitch_o[gi] = glitch_reg;
`endif
    end

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed and random checks of two sync_filter instances against a window-based model.
// Instance a: 4 ch, 3 stages, 4-cycle filter, reset 1010. Instance b: 4 ch, 3 stages, no filtering.
module tb_sync_filter;

    localparam int         ST  = 3;
    localparam int         FCA = 4;
    localparam int         FCB = 1;
    localparam logic [3:0] RVA = 4'b1010;
    localparam logic [3:0] RVB = 4'b0000;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] in_a   = '0;
    logic [3:0] in_b   = '0;
    logic [3:0] gclr_a = '0;
    logic [3:0] so_a, ri_a, fa_a;
    logic [3:0] so_b, ri_b, fa_b;
`ifdef SYNC_FILTER_GLITCH_DETECT_EN
    logic [3:0] gclr_b = '0;
    logic [3:0] gl_a, gl_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: sample history, history of values seen at the last sync stage, filtered/previous level.
    logic [3:0] m_samp [2][8];
    logic [3:0] m_s    [2][8];
    int         m_n    [2];
    int         m_ns   [2];
    logic [3:0] m_f    [2];
    logic [3:0] m_p    [2];
    logic [3:0] m_g;

    int cnt_rise0, cnt_fall0, cnt_high0;

    always #5 clk = ~clk;

    sync_filter #(.NUM_CH(4), .STAGES(ST), .FILTER_CYCLES(FCA), .RESET_VALUE(RVA)) dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .serial_i (in_a),
        .serial_o (so_a),
        .rise_o   (ri_a),
        .fall_o   (fa_a)
`ifdef SYNC_FILTER_GLITCH_DETECT_EN
        ,
        .glitch_clr_i (gclr_a),
        .glitch_o     (gl_a)
`endif
    );

    sync_filter #(.NUM_CH(4), .STAGES(ST), .FILTER_CYCLES(FCB), .RESET_VALUE(RVB)) dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .serial_i (in_b),
        .serial_o (so_b),
        .rise_o   (ri_b),
        .fall_o   (fa_b)
`ifdef SYNC_FILTER_GLITCH_DETECT_EN
        ,
        .glitch_clr_i (gclr_b),
        .glitch_o     (gl_b)
`endif
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]  = 0;
            m_ns[i] = 0;
            m_f[i]  = (i == 0) ? RVA : RVB;
            m_p[i]  = (i == 0) ? RVA : RVB;
        end
        m_g = '0;
    endtask

    // A level is accepted once the last FC values at the sync output all disagree with the current level.
    task automatic model_edge();
        logic [3:0] inp [2];
        logic [3:0] s_now, nf, gset;
        int         fc;
        bit         all_diff;
        inp[0] = in_a;
        inp[1] = in_b;
        for (int i = 0; i < 2; i++) begin
            fc    = (i == 0) ? FCA : FCB;
            s_now = (m_n[i] >= ST) ? m_samp[i][ST-1] : ((i == 0) ? RVA : RVB);
            for (int j = 7; j > 0; j--) m_s[i][j] = m_s[i][j-1];
            m_s[i][0] = s_now;
            if (m_ns[i] < 8) m_ns[i]++;
            if (i == 0) begin
                gset = (m_ns[0] >= 2) ? (~(s_now ^ m_f[0]) & (m_s[0][1] ^ m_f[0])) : 4'b0000;
                m_g  = gset | (m_g & ~gclr_a);
            end
            nf = m_f[i];
            for (int c = 0; c < 4; c++) begin
                all_diff = (m_ns[i] >= fc);
                for (int j = 0; j < fc; j++)
                    if (m_s[i][j][c] == m_f[i][c]) all_diff = 1'b0;
                if (all_diff) nf[c] = ~m_f[i][c];
            end
            m_p[i] = m_f[i];
            m_f[i] = nf;
            for (int j = 7; j > 0; j--) m_samp[i][j] = m_samp[i][j-1];
            m_samp[i][0] = inp[i];
            if (m_n[i] < 8) m_n[i]++;
        end
    endtask

    task automatic check_all();
        check("serial_a", so_a, m_f[0]);
        check("rise_a",   ri_a, m_f[0] & ~m_p[0]);
        check("fall_a",   fa_a, ~m_f[0] & m_p[0]);
        check("serial_b", so_b, m_f[1]);
        check("rise_b",   ri_b, m_f[1] & ~m_p[1]);
        check("fall_b",   fa_b, ~m_f[1] & m_p[1]);
`ifdef SYNC_FILTER_GLITCH_DETECT_EN
        check("glitch_a", gl_a, m_g);
        check("glitch_b", gl_b, 4'b0000);
`endif
    endtask

    task automatic cycle(input logic [3:0] a, input logic [3:0] b);
        in_a = a;
        in_b = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (ri_a[0]) cnt_rise0++;
        if (fa_a[0]) cnt_fall0++;
        if (so_a[0]) cnt_high0++;
    endtask

    task automatic run_a(input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) cycle(a, in_b);
    endtask

    task automatic clear_counts();
        cnt_rise0 = 0;
        cnt_fall0 = 0;
        cnt_high0 = 0;
    endtask

    initial begin
        int         first;
        int         rc [4];
        logic [3:0] fm;

        // Reset held with inputs at 0: outputs sit at the reset value with no pulses.
        model_reset();
        clear_counts();
        repeat (3) begin
            @(negedge clk);
            check_all();
            check("rst_level_a", so_a, RVA);
        end

        // Release: channels 1 and 3 fall after STAGES+FILTER_CYCLES edges, nothing at release itself.
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cycle(4'b0000, 4'b0000);
            check("rel_fall_a", fa_a, (k == ST + FCA) ? 4'b1010 : 4'b0000);
            check("rel_rise_a", ri_a, 4'b0000);
        end

        // Latency on the unfiltered instance: rise seen after the STAGES+1-th edge counting the sampling edge.
        first = -1;
        for (int k = 0; k < 8; k++) begin
            cycle(4'b0000, 4'b0001);
            if (ri_b[0] && first < 0) first = k;
        end
        check_int("latency_b", first, ST + FCB - 1);
        run_a(4'b0000, 6);

        // Glitch rejection: a 3-cycle pulse vanishes, a 4-cycle pulse passes for exactly 4 cycles.
        clear_counts();
        run_a(4'b0001, 3);
        run_a(4'b0000, 10);
        check_int("short_pulse_rise", cnt_rise0, 0);
        check_int("short_pulse_high", cnt_high0, 0);
        clear_counts();
        run_a(4'b0001, 4);
        run_a(4'b0000, 12);
        check_int("pulse4_rise", cnt_rise0, 1);
        check_int("pulse4_fall", cnt_fall0, 1);
        check_int("pulse4_high", cnt_high0, FCA);

        // Counter restart: high 3, low 1, high 4 gives a single rise after the second run.
        clear_counts();
        first = -1;
        run_a(4'b0001, 3);
        run_a(4'b0000, 1);
        for (int k = 0; k < 10; k++) begin
            cycle((k < 4) ? 4'b0001 : 4'b0000, in_b);
            if (ri_a[0] && first < 0) first = k;
        end
        run_a(4'b0000, 10);
        check_int("restart_rises", cnt_rise0, 1);
        check_int("restart_rise_time", first, ST + FCA - 1);

        // Independence: ch0/ch2 together, ch1 two cycles later, ch3 idle.
        rc = '{-1, -1, -1, -1};
        for (int k = 0; k < 14; k++) begin
            cycle((k >= 2) ? 4'b0111 : 4'b0101, in_b);
            for (int c = 0; c < 4; c++)
                if (ri_a[c] && rc[c] < 0) rc[c] = k;
        end
        check_int("indep_ch0", rc[0], ST + FCA - 1);
        check_int("indep_ch2", rc[2], rc[0]);
        check_int("indep_ch1", rc[1], rc[0] + 2);
        check_int("indep_ch3", rc[3], -1);
        run_a(4'b0000, 12);

        // Mid-operation reset with a filter count in progress on ch0.
        run_a(4'b0001, ST + FCA - 2);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        check("midrst_serial_a", so_a, RVA);
        check("midrst_rise_a", ri_a, 4'b0000);
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        in_a  = RVA;
        rst_n = 1'b1;
        run_a(RVA, 10);
        check("post_rst_level_a", so_a, RVA);

`ifdef SYNC_FILTER_GLITCH_DETECT_EN
        check("glitch_after_rst", gl_a, 4'b0000);
        run_a(4'b1011, 1);
        run_a(RVA, 6);
        check("glitch_set", gl_a, 4'b0001);
        gclr_a = 4'b0001;
        run_a(RVA, 1);
        gclr_a = 4'b0000;
        run_a(RVA, 1);
        check("glitch_clr", gl_a, 4'b0000);
`endif

        // Random: sparse toggles on the filtered instance, free-running bits on the unfiltered one.
        for (int k = 0; k < 400; k++) begin
            fm     = 4'($urandom) & 4'($urandom);
            gclr_a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cycle(in_a ^ fm, 4'($urandom));
        end
        gclr_a = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Multi-channel, parametrised input synchronizer with a per-channel glitch filter and edge-pulse outputs.
- Sits at asynchronous pin/domain boundaries: GPIO inputs, external interrupts, slow status lines.
- Replaces hand-instantiated arrays of plain two-flop synchronizers plus ad-hoc debounce and edge logic.

Parameters:
- NUM_CH, 1, number of independent channels.
- STAGES, 2, synchronizer flop depth per channel; legal range 2..8.
- FILTER_CYCLES, 1, consecutive cycles a synchronized value must persist before it is accepted. Minimum 1; a value of 1 means no filtering.
- RESET_VALUE, '0 (NUM_CH bits), per-channel reset value for all synchronizer stages, the filtered output and the edge history.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- serial_i  input  NUM_CH  asynchronous inputs
- serial_o  output  NUM_CH  synchronized, filtered level
- rise_o  output  NUM_CH  one-cycle pulse on a 0->1 transition of serial_o
- fall_o  output  NUM_CH  one-cycle pulse on a 1->0 transition of serial_o

Behaviour:
- Clocking and reset: single clock domain clk_i; reset rst_ni is asynchronous, active-low.
- Reset values, per channel c:
  - all STAGES sync flops = RESET_VALUE[c]
  - filtered flop f = RESET_VALUE[c]
  - edge history flop p = RESET_VALUE[c]
  - filter counter = 0
  - Therefore serial_o = RESET_VALUE and rise_o = fall_o = 0 during and right after reset. No spurious edge pulse after reset release.
- Synchronizer: a shift chain of STAGES flops; s = last stage. No logic between stages.
- Filter, counter width $clog2(FILTER_CYCLES), minimum 1 bit:
  - s == f: counter <= 0.
  - s != f and counter == FILTER_CYCLES-1: f <= s, counter <= 0.
  - s != f otherwise: counter <= counter+1.
  - A mismatch that disappears before acceptance resets the counter. Acceptance needs FILTER_CYCLES consecutive mismatching cycles, not a cumulative count.
- serial_o = f (registered output, no combinational path from serial_i).
- Latency: a clean step on serial_i sampled at edge k appears on serial_o after edge k+STAGES+FILTER_CYCLES-1. Total is STAGES+FILTER_CYCLES cycles, including the sampling edge.
- Edges: p <= f every cycle.
  - rise_o = f & ~p; fall_o = ~f & p.
  - Each pulse lasts exactly one cycle, in the first cycle serial_o shows the new level.
  - rise_o and fall_o are never both high on one channel.
- Glitch rejection: a pulse shorter than FILTER_CYCLES cycles at s is never visible on serial_o, rise_o or fall_o.
- Channels are fully independent; simultaneous events on different channels produce simultaneous pulses.
- Reset mid-operation: all state returns to reset values asynchronously. A filter count in progress is discarded; no pulse is generated on reset assertion or release.
- Elaboration-time assertions: STAGES >= 2, FILTER_CYCLES >= 1, NUM_CH >= 1.

Optional Feature:
- Macro SYNC_FILTER_GLITCH_DETECT_EN.
- When defined, two ports are added: glitch_clr_i (input, NUM_CH) and glitch_o (output, NUM_CH).
  - glitch_o[c] is a sticky flag. It sets in the cycle s == f while counter != 0, i.e. a rejected glitch.
  - glitch_clr_i[c] clears the flag; set wins over clear in the same cycle.
  - The flag resets to 0.
- When undefined: neither port exists, no extra flops are built, and all other behaviour is identical.
- With FILTER_CYCLES = 1 the flag never sets.

Test Plan:
- Reset, with NUM_CH=4, RESET_VALUE=4'b1010, serial_i=4'b0000 held:
  - serial_o = 4'b1010 during reset.
  - After release: falls on ch1 and ch3 at cycle STAGES+FILTER_CYCLES; rise_o = 0 throughout; no pulses at release itself.
- Latency, with STAGES=3, FILTER_CYCLES=1: step serial_i[0] 0->1 at edge 10 -> serial_o[0]=1 and rise_o[0]=1 after edge 13, rise_o[0]=0 after edge 14.
- Glitch rejection, with FILTER_CYCLES=4: 3-cycle high pulse -> serial_o stays 0, no rise_o. A 4-cycle pulse -> serial_o high for exactly 4 cycles, one rise_o and one fall_o.
- Counter restart, with FILTER_CYCLES=4: pattern high 3, low 1, high 4 -> exactly one rise, occurring after the second high run completes.
- Independence: toggle ch0 and ch2 on the same edge and ch1 two cycles later -> matching pulses with identical latency; ch3 untouched.
- Mid-operation reset: assert rst_ni while a counter is at FILTER_CYCLES-2 -> outputs immediately return to RESET_VALUE, no pulses. With the macro defined, glitch_o also clears, then sets after a 1-cycle glitch and clears on glitch_clr_i.
